boreal_ledger: RTL and testbench

Bus responder for the ledger slot (0x1005_xxxx) of the SoC interconnect. It implements an append-only audit log: a circular entry buffer, a monotonic sequence counter and a chained running digest. A seal control freezes the log. The block sits on the slave side of the interconnect's sel/wr/addr/wdata → rdata/ack protocol.

---
 rtl/boreal_ledger_pkg.sv | 12 +
 rtl/boreal_ledger_mem.sv | 19 +
 rtl/boreal_ledger.sv | 127 ++++++++++++
 tb/tb_boreal_ledger.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/boreal_ledger_pkg.sv
// boreal_ledger_pkg: register offsets, slot base and handshake state type for the ledger responder
package boreal_ledger_pkg;
    localparam logic [31:0] LEDGER_BASE   = 32'h1005_0000;
    localparam logic [7:0]  LEDGER_CTRL   = 8'h00;
    localparam logic [7:0]  LEDGER_STATUS = 8'h04;
    localparam logic [7:0]  LEDGER_APPEND = 8'h08;
    localparam logic [7:0]  LEDGER_SEQ    = 8'h0C;
    localparam logic [7:0]  LEDGER_RDIDX  = 8'h10;
    localparam logic [7:0]  LEDGER_RDDATA = 8'h14;
    localparam logic [7:0]  LEDGER_DIGEST = 8'h18;
    typedef enum logic {ST_IDLE, ST_ACK} ledger_state_t;
endpackage

// File: rtl/boreal_ledger_mem.sv
// boreal_ledger_mem: DEPTHx32 entry array, synchronous write, asynchronous read, no reset
module boreal_ledger_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    // store one entry per accepted append
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/boreal_ledger.sv
// boreal_ledger: append-only audit log slave with sequence counter, chained digest and seal
module boreal_ledger
    import boreal_ledger_pkg::*;
#(
    parameter int          DEPTH       = 16,
    parameter logic [31:0] DIGEST_INIT = 32'h5A5A_5A5A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ledger_sel,
    input  logic        ledger_wr,
    input  logic [31:0] ledger_addr,
    input  logic [31:0] ledger_wdata,
    output logic [31:0] ledger_rdata,
    output logic        ledger_ack,
    output logic        ledger_full,
    output logic        ledger_sealed
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ledger_state_t r_state, w_next;
    logic [31:0]   r_rdata, r_seq, r_digest;
    logic [AW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count, r_rdidx;
    logic          r_sealed, r_overflow, r_rejected;
    logic          w_access, w_full, w_append, w_rd_hit;
    logic [7:0]    w_off;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_mem_rdata, w_rdval;
    logic          w_unused;

    function automatic logic [31:0] f_digest(input logic [31:0] d, input logic [31:0] w, input logic [31:0] s);
        return {d[26:0], d[31:27]} ^ w ^ s;
    endfunction

    assign w_unused  = ^{ledger_addr[31:8], ledger_addr[1:0]};
    assign w_off     = {ledger_addr[7:2], 2'b00};
    assign w_full    = r_count == CW'(DEPTH);
    assign w_rd_hit  = r_rdidx < r_count;
    assign w_raddr   = r_head + r_rdidx[AW-1:0];
    assign w_append  = w_access && ledger_wr && w_off == LEDGER_APPEND && !r_sealed && !w_full;

    boreal_ledger_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (w_append),
        .i_waddr (r_tail),
        .i_wdata (ledger_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    // handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // one access per IDLE with sel; ACK always returns to IDLE ignoring sel
    always_comb begin
        w_access = r_state == ST_IDLE && ledger_sel;
        w_next   = w_access ? ST_ACK : ST_IDLE;
    end

    // read data mux over the register map
    always_comb begin
        w_rdval = 32'h0;
        case (w_off)
            LEDGER_CTRL:   w_rdval = {31'h0, r_sealed};
            LEDGER_STATUS: w_rdval = {15'h0, 9'(r_count), 3'h0, r_rejected, r_overflow, r_sealed, w_full, r_count == '0};
            LEDGER_SEQ:    w_rdval = r_seq;
            LEDGER_RDIDX:  w_rdval = 32'(r_rdidx);
            LEDGER_RDDATA: w_rdval = w_rd_hit ? w_mem_rdata : 32'h0;
            LEDGER_DIGEST: w_rdval = r_digest;
            default:       w_rdval = 32'h0;
        endcase
    end

    // commit writes and register read data on the IDLE->ACK transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_digest   <= DIGEST_INIT;
            r_sealed   <= 1'b0;
            r_overflow <= 1'b0;
            r_rejected <= 1'b0;
            r_rdidx    <= '0;
        end else if (w_access) begin
            r_rdata <= ledger_wr ? 32'h0 : w_rdval;
            if (ledger_wr) begin
                case (w_off)
                    LEDGER_CTRL: begin
                        if (ledger_wdata[1] && !r_sealed) begin
                            r_head     <= '0;
                            r_tail     <= '0;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                            r_rejected <= 1'b0;
                        end
                        if (ledger_wdata[0]) r_sealed <= 1'b1;
                    end
                    LEDGER_APPEND: begin
                        if (r_sealed) r_rejected <= 1'b1;
                        else if (w_full) r_overflow <= 1'b1;
                        else begin
                            r_tail   <= r_tail + AW'(1);
                            r_count  <= r_count + CW'(1);
                            r_digest <= f_digest(r_digest, ledger_wdata, r_seq);
                            r_seq    <= r_seq + 32'd1;
                        end
                    end
                    LEDGER_RDIDX: r_rdidx <= ledger_wdata[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign ledger_ack    = r_state == ST_ACK;
    assign ledger_rdata  = r_rdata;
    assign ledger_full   = w_full;
    assign ledger_sealed = r_sealed;
endmodule

// File: tb/tb_boreal_ledger.sv
// tb_boreal_ledger: directed and randomized bus traffic against a queue-based log model
module tb_boreal_ledger;
    import boreal_ledger_pkg::*;
    localparam int DEPTH = 16;

    logic        clk = 0, rst_n = 0, sel = 0, wr = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata;
    logic        ack, full, sealed;

    boreal_ledger #(.DEPTH(DEPTH), .DIGEST_INIT(32'h5A5A_5A5A)) dut (
        .clk(clk), .rst_n(rst_n), .ledger_sel(sel), .ledger_wr(wr),
        .ledger_addr(addr), .ledger_wdata(wdata), .ledger_rdata(rdata),
        .ledger_ack(ack), .ledger_full(full), .ledger_sealed(sealed)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    logic [31:0] m_q[$];
    logic [31:0] m_seq, m_dig;
    bit          m_sealed, m_ovf, m_rej;
    int unsigned m_rdidx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_seq = 0; m_dig = 32'h5A5A_5A5A;
        m_sealed = 0; m_ovf = 0; m_rej = 0; m_rdidx = 0;
    endtask

    function automatic logic [31:0] m_status();
        int n = m_q.size();
        return (n == 0 ? 1 : 0) + (n == DEPTH ? 2 : 0) + (m_sealed ? 4 : 0)
             + (m_ovf ? 8 : 0) + (m_rej ? 16 : 0) + n * 256;
    endfunction

    task automatic m_apply(input logic w, input logic [7:0] off, input logic [31:0] d, output logic [31:0] exp);
        exp = 0;
        if (w) begin
            if (off == LEDGER_CTRL) begin
                if (d[1] && !m_sealed) begin m_q.delete(); m_ovf = 0; m_rej = 0; end
                if (d[0]) m_sealed = 1;
            end else if (off == LEDGER_APPEND) begin
                if (m_sealed) m_rej = 1;
                else if (m_q.size() == DEPTH) m_ovf = 1;
                else begin
                    m_q.push_back(d);
                    m_dig = ((m_dig << 5) | (m_dig >> 27)) ^ d ^ m_seq;
                    m_seq = m_seq + 1;
                end
            end else if (off == LEDGER_RDIDX) m_rdidx = d % (2 * DEPTH);
        end else begin
            if (off == LEDGER_CTRL) exp = m_sealed ? 1 : 0;
            else if (off == LEDGER_STATUS) exp = m_status();
            else if (off == LEDGER_SEQ) exp = m_seq;
            else if (off == LEDGER_RDIDX) exp = m_rdidx;
            else if (off == LEDGER_RDDATA) exp = m_rdidx < m_q.size() ? m_q[m_rdidx] : 0;
            else if (off == LEDGER_DIGEST) exp = m_dig;
        end
    endtask

    task automatic op(input logic w, input logic [7:0] off, input logic [31:0] d, output logic [31:0] got);
        logic [31:0] exp;
        m_apply(w, off, d, exp);
        @(negedge clk);
        sel = 1; wr = w; wdata = d;
        addr = ($urandom & 32'hFFFF_FF03) | {24'h0, off};
        @(posedge clk); #1;
        check("ack_rise", 32'(ack), 1);
        got = rdata;
        check($sformatf("%s_%02h", w ? "wr" : "rd", off), rdata, exp);
        sel = 0; wr = 0;
        @(posedge clk); #1;
        check("ack_fall", 32'(ack), 0);
        check("full_pin", 32'(full), 32'(m_q.size() == DEPTH));
        check("sealed_pin", 32'(sealed), 32'(m_sealed));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; sel = 0; wr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    logic [31:0] got;
    logic [7:0]  offs[9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h3C};
    logic [7:0]  ro[4]   = '{8'h04, 8'h0C, 8'h14, 8'h18};
    int          n_ack;

    initial begin
        m_reset();
        do_reset();
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_rdata", rdata, 0);
        check("rst_full", 32'(full), 0);
        check("rst_sealed", 32'(sealed), 0);

        op(0, LEDGER_STATUS, 0, got); check("p1_status", got, 32'h1);
        op(0, LEDGER_DIGEST, 0, got); check("p1_digest", got, 32'h5A5A_5A5A);

        op(1, LEDGER_APPEND, 32'h1, got);
        op(0, LEDGER_SEQ, 0, got);    check("p2_seq", got, 32'h1);
        op(0, LEDGER_DIGEST, 0, got); check("p2_digest", got, 32'h4B4B_4B4A);
        op(0, LEDGER_STATUS, 0, got); check("p2_status", got, 32'h100);
        op(1, LEDGER_RDIDX, 0, got);
        op(0, LEDGER_RDDATA, 0, got); check("p2_rd0", got, 32'h1);
        op(1, LEDGER_RDIDX, 1, got);
        op(0, LEDGER_RDDATA, 0, got); check("p2_rd1", got, 32'h0);

        op(1, LEDGER_APPEND, 32'hDEAD_0002, got);
        op(1, LEDGER_CTRL, 32'h2, got);
        op(0, LEDGER_STATUS, 0, got); check("p6_status", got, 32'h1);
        op(0, LEDGER_SEQ, 0, got);    check("p6_seq", got, 32'h2);
        op(0, LEDGER_DIGEST, 0, got);
        op(1, LEDGER_APPEND, 32'hCAFE_0003, got);
        op(1, LEDGER_RDIDX, 0, got);
        op(0, LEDGER_RDDATA, 0, got); check("p6_land", got, 32'hCAFE_0003);
        op(1, 8'h3C, 32'hFFFF_FFFF, got);
        op(0, 8'h3C, 0, got);         check("p6_undef", got, 32'h0);

        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op(1, LEDGER_APPEND, $urandom, got);
                5: op(0, offs[$urandom_range(0, 8)], 0, got);
                6: op(1, LEDGER_RDIDX, $urandom, got);
                7: op(0, LEDGER_RDDATA, 0, got);
                8: if ($urandom_range(0, 3) == 0) op(1, LEDGER_CTRL, 32'h2, got);
                   else op(0, LEDGER_STATUS, 0, got);
                default: op(1, ro[$urandom_range(0, 3)], $urandom, got);
            endcase
        end
        op(0, LEDGER_DIGEST, 0, got);

        op(1, LEDGER_CTRL, 32'h2, got);
        for (int i = 0; i < 16; i++) op(1, LEDGER_APPEND, 32'h100 + i, got);
        op(1, LEDGER_APPEND, 32'hFFFF_FFFF, got);
        op(0, LEDGER_STATUS, 0, got); check("p3_status", got, 32'h100A);
        check("p3_full_pin", 32'(full), 1);
        op(0, LEDGER_SEQ, 0, got);
        op(1, LEDGER_RDIDX, 15, got);
        op(0, LEDGER_RDDATA, 0, got); check("p3_rd15", got, 32'h10F);

        op(1, LEDGER_CTRL, 32'h1, got);
        op(1, LEDGER_APPEND, 32'h1234_5678, got);
        op(1, LEDGER_CTRL, 32'h2, got);
        op(0, LEDGER_STATUS, 0, got); check("p4_status", got, 32'h101E);
        op(0, LEDGER_SEQ, 0, got);
        op(0, LEDGER_CTRL, 0, got);   check("p4_ctrl", got, 32'h1);
        check("p4_sealed_pin", 32'(sealed), 1);

        do_reset();
        sel = 1; wr = 0; addr = LEDGER_BASE | 32'(LEDGER_SEQ);
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("held_ack%0d", i), 32'(ack), 32'(i % 2 == 0));
            if (ack) begin
                n_ack++;
                check("held_rdata", rdata, 0);
            end
        end
        sel = 0;
        check("held_count", n_ack, 3);
        @(posedge clk); #1;
        check("held_idle", 32'(ack), 0);

        @(negedge clk);
        sel = 1; wr = 1; addr = LEDGER_BASE | 32'(LEDGER_APPEND); wdata = 32'h7777_7777;
        #2 rst_n = 0;
        @(posedge clk); #1;
        check("rst_mid_ack", 32'(ack), 0);
        @(negedge clk);
        sel = 0; wr = 0; rst_n = 1;
        m_reset();
        @(posedge clk); #1;
        check("rst_mid_ack2", 32'(ack), 0);
        op(0, LEDGER_SEQ, 0, got);    check("p5_seq", got, 32'h0);
        op(0, LEDGER_STATUS, 0, got); check("p5_status", got, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
